// File: rtl/octree_seq_pkg.sv
// Shared types and constants for the octree command sequencer: state/op enums,
// CSR0 field offsets, default bus addresses and the FIFO command image.
package octree_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_CSR0  = 3'd1,
    ST_WR_CSR1  = 3'd2,
    ST_POLL_REQ = 3'd3,
    ST_POLL_CHK = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_SEARCH = 2'b01,
    OP_ADD    = 2'b10,
    OP_DELETE = 2'b11
  } op_e;

  localparam int CSR0_CTRL_LSB    = 48;
  localparam int CSR0_SRAM_EN_LSB = 16;

  localparam logic [63:0] DEF_CSR0_ADDR    = 64'h6000_0000;
  localparam logic [63:0] DEF_CSR1_ADDR    = 64'h6001_0000;
  localparam logic [63:0] DEF_STATUS_ADDR  = 64'h600f_0000;
  localparam logic [63:0] DEF_IDLE_PATTERN = 64'hDEADBEEF_DEADBEEF;

  localparam int CMD_W = 130;

  typedef struct packed {
    op_e         op;
    logic [63:0] csr0;
    logic [63:0] csr1;
  } cmd_t;

  // Op code goes into the ctrl field; the sram-enable field is always cleared.
  function automatic logic [63:0] csr0_image(input logic [63:0] csr0, input op_e op);
    logic [63:0] w;
    w = csr0;
    w[CSR0_CTRL_LSB +: 2]    = op;
    w[CSR0_SRAM_EN_LSB +: 2] = 2'b00;
    return w;
  endfunction

  function automatic logic [7:0] err_sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/octree_seq_fifo.sv
// Command FIFO, show-ahead read data, zero-latency pop; push ignored when full,
// pop ignored when empty. Occupancy tracked by an explicit count register.
module octree_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 130
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/octree_cmd_sequencer.sv
// Queues octree commands and replays each as CSR0/CSR1 writes plus status polling;
// pop-to-done is 5 cycles minimum, cmd_ready_o drops while the FIFO is full.
module octree_cmd_sequencer
  import octree_seq_pkg::*;
#(
  parameter int          CMD_DEPTH    = 4,
  parameter int          POLL_MAX     = 3000,
  parameter logic [63:0] CSR0_ADDR    = DEF_CSR0_ADDR,
  parameter logic [63:0] CSR1_ADDR    = DEF_CSR1_ADDR,
  parameter logic [63:0] STATUS_ADDR  = DEF_STATUS_ADDR,
  parameter logic [63:0] IDLE_PATTERN = DEF_IDLE_PATTERN
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [63:0] cmd_csr0_i,
  input  logic [63:0] cmd_csr1_i,
  output logic        mem_req_o,
  output logic        mem_write_en_o,
  output logic [7:0]  mem_byte_en_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic [63:0] mem_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [63:0] last_status_o,
  output logic [7:0]  err_cnt_o
);

  localparam int             PCW       = $clog2(POLL_MAX + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX);

  state_e         state;
  cmd_t           fifo_wr;
  cmd_t           fifo_rd;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;
  logic [63:0]    csr1_q;
  logic [PCW-1:0] poll_cnt;
  logic           op_rej;
  logic           status_done;
  logic           poll_expired;

  assign cmd_ready_o   = rstn_i && !fifo_full;
  assign fifo_push     = cmd_valid_i && cmd_ready_o && (cmd_op_i != 2'b00);
  assign op_rej        = cmd_valid_i && cmd_ready_o && (cmd_op_i == 2'b00);
  assign fifo_pop      = (state == ST_IDLE) && !fifo_empty;
  assign fifo_wr       = '{op: op_e'(cmd_op_i), csr0: cmd_csr0_i, csr1: cmd_csr1_i};
  assign status_done   = (state == ST_POLL_CHK) && (mem_rdata_i != IDLE_PATTERN)
                         && (mem_rdata_i != 64'd0);
  assign poll_expired  = (state == ST_POLL_CHK) && !status_done && (poll_cnt == POLL_LAST);
  assign busy_o        = rstn_i && ((state != ST_IDLE) || !fifo_empty);
  assign mem_byte_en_o = 8'hFF;

  octree_seq_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_dat (fifo_wr),
    .rd_dat (fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Bus outputs are loaded on the transition into each state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state          <= ST_IDLE;
      csr1_q         <= '0;
      poll_cnt       <= '0;
      mem_req_o      <= 1'b0;
      mem_write_en_o <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
      last_status_o  <= '0;
      err_cnt_o      <= '0;
    end else begin
      mem_req_o      <= 1'b0;
      mem_write_en_o <= 1'b0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
      err_cnt_o      <= err_sat_add(err_cnt_o, {1'b0, op_rej} + {1'b0, poll_expired});
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            csr1_q         <= fifo_rd.csr1;
            poll_cnt       <= '0;
            mem_req_o      <= 1'b1;
            mem_write_en_o <= 1'b1;
            mem_addr_o     <= CSR0_ADDR;
            mem_wdata_o    <= csr0_image(fifo_rd.csr0, fifo_rd.op);
            state          <= ST_WR_CSR0;
          end
        end
        ST_WR_CSR0: begin
          mem_req_o      <= 1'b1;
          mem_write_en_o <= 1'b1;
          mem_addr_o     <= CSR1_ADDR;
          mem_wdata_o    <= csr1_q;
          state          <= ST_WR_CSR1;
        end
        ST_WR_CSR1: begin
          mem_req_o  <= 1'b1;
          mem_addr_o <= STATUS_ADDR;
          state      <= ST_POLL_REQ;
        end
        ST_POLL_REQ: begin
          poll_cnt <= poll_cnt + 1'b1;
          state    <= ST_POLL_CHK;
        end
        ST_POLL_CHK: begin
          if (status_done) begin
            last_status_o <= mem_rdata_i;
            done_o        <= 1'b1;
            state         <= ST_IDLE;
          end else if (poll_expired) begin
            timeout_o <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            mem_req_o <= 1'b1;
            state     <= ST_POLL_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_octree_cmd_sequencer.sv
// Directed bench for octree_cmd_sequencer with a one-cycle-latency status responder.
module tb_octree_cmd_sequencer;

  localparam logic [63:0] IDLE_P = 64'hDEADBEEF_DEADBEEF;
  localparam logic [63:0] CSR0_A = 64'h6000_0000;
  localparam logic [63:0] CSR1_A = 64'h6001_0000;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic [1:0]  cmd_op_i = 2'b00;
  logic [63:0] cmd_csr0_i = '0;
  logic [63:0] cmd_csr1_i = '0;
  logic [63:0] mem_rdata_i = '0;
  logic        cmd_ready_o, mem_req_o, mem_write_en_o, busy_o, done_o, timeout_o;
  logic [7:0]  mem_byte_en_o, err_cnt_o;
  logic [63:0] mem_addr_o, mem_wdata_o, last_status_o;

  int tests = 0;
  int fails = 0;

  octree_cmd_sequencer #(
    .CMD_DEPTH (4),
    .POLL_MAX  (8)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_op_i       (cmd_op_i),
    .cmd_csr0_i     (cmd_csr0_i),
    .cmd_csr1_i     (cmd_csr1_i),
    .mem_req_o      (mem_req_o),
    .mem_write_en_o (mem_write_en_o),
    .mem_byte_en_o  (mem_byte_en_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o),
    .last_status_o  (last_status_o),
    .err_cnt_o      (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Status script: read k of the current test returns st_tab[k], then st_def.
  logic [63:0] st_tab [16];
  int          st_len = 0;
  logic [63:0] st_def = IDLE_P;
  int          st_base = 0;
  int          rsp_n = 0;
  int          cyc = 0;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_req_o && !mem_write_en_o) begin
      if (rsp_n - st_base < st_len) mem_rdata_i <= st_tab[rsp_n - st_base];
      else                          mem_rdata_i <= st_def;
      rsp_n <= rsp_n + 1;
    end else begin
      mem_rdata_i <= 64'h0;
    end
  end

  logic [63:0] wr_addr [$];
  logic [63:0] wr_data [$];
  int          wr_cyc  [$];
  int          done_cyc [$];
  int          n_rd = 0;
  int          n_to = 0;

  always @(negedge clk_i) begin
    if (mem_req_o && mem_write_en_o) begin
      wr_addr.push_back(mem_addr_o);
      wr_data.push_back(mem_wdata_o);
      wr_cyc.push_back(cyc);
    end
    if (mem_req_o && !mem_write_en_o) n_rd++;
    if (done_o) done_cyc.push_back(cyc);
    if (timeout_o) n_to++;
  end

  task automatic push_cmd(input logic [1:0] op, input logic [63:0] c0, input logic [63:0] c1,
                          output int waited);
    waited = 0;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_csr0_i  = c0;
    cmd_csr1_i  = c1;
    while (!cmd_ready_o && waited < 300) begin
      @(negedge clk_i);
      waited++;
    end
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int t = 0;
    while (done_cyc.size() < target && t < budget) begin
      @(negedge clk_i);
      t++;
    end
    ok = (done_cyc.size() >= target);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic set_script(input int len, input logic [63:0] def);
    st_len  = len;
    st_def  = def;
    st_base = rsp_n;
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", mem_req_o); end
    tests++; if (mem_write_en_o !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", mem_write_en_o); end
    tests++; if (mem_byte_en_o !== 8'hFF) begin fails++; $display("FAIL reset_be got %h want ff", mem_byte_en_o); end
    tests++; if (mem_addr_o !== 64'h0) begin fails++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
    tests++; if ({busy_o, done_o, timeout_o} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {busy_o, done_o, timeout_o}); end
    tests++; if (last_status_o !== 64'h0) begin fails++; $display("FAIL reset_status got %h want 0", last_status_o); end
    tests++; if (err_cnt_o !== 8'h0) begin fails++; $display("FAIL reset_err got %h want 0", err_cnt_o); end
    tests++; if (cmd_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready_low got %b want 0", cmd_ready_o); end
    rstn_i = 1'b1;
    @(negedge clk_i);
    tests++; if (cmd_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready_rel got %b want 1", cmd_ready_o); end
  endtask

  task automatic test_delete;
    int w0, d0, r0, wt;
    bit ok;
    w0 = wr_addr.size(); d0 = done_cyc.size(); r0 = n_rd;
    st_tab[0] = IDLE_P; st_tab[1] = IDLE_P; st_tab[2] = 64'h1;
    set_script(3, IDLE_P);
    push_cmd(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00A5, wt);
    wait_done(d0 + 1, 40, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL del_done got %b want 1", ok); end
    tests++; if (wr_addr.size() - w0 !== 2) begin fails++; $display("FAIL del_nwr got %0d want 2", wr_addr.size() - w0); end
    tests++; if (wr_addr[w0] !== CSR0_A) begin fails++; $display("FAIL del_a0 got %h want %h", wr_addr[w0], CSR0_A); end
    tests++; if (wr_data[w0] !== 64'hFFFF_FFFF_FFFC_FFFF) begin fails++; $display("FAIL del_d0 got %h want fffffffffffcffff", wr_data[w0]); end
    tests++; if (wr_addr[w0+1] !== CSR1_A) begin fails++; $display("FAIL del_a1 got %h want %h", wr_addr[w0+1], CSR1_A); end
    tests++; if (wr_data[w0+1] !== 64'hA5) begin fails++; $display("FAIL del_d1 got %h want a5", wr_data[w0+1]); end
    tests++; if (n_rd - r0 !== 3) begin fails++; $display("FAIL del_reads got %0d want 3", n_rd - r0); end
    tests++; if (done_cyc[d0] - wr_cyc[w0] !== 8) begin fails++; $display("FAIL del_latency got %0d want 8", done_cyc[d0] - wr_cyc[w0]); end
    tests++; if (done_cyc.size() - d0 !== 1) begin fails++; $display("FAIL del_pulse got %0d want 1", done_cyc.size() - d0); end
    tests++; if (last_status_o !== 64'h1) begin fails++; $display("FAIL del_status got %h want 1", last_status_o); end
  endtask

  task automatic test_timeout;
    int w0, d0, r0, t0, wt, t;
    w0 = wr_addr.size(); d0 = done_cyc.size(); r0 = n_rd; t0 = n_to; t = 0;
    set_script(0, IDLE_P);
    push_cmd(2'b10, 64'h0003_0000_0003_0000, 64'h0, wt);
    while (n_to == t0 && t < 100) begin @(negedge clk_i); t++; end
    repeat (4) @(negedge clk_i);
    tests++; if (n_to - t0 !== 1) begin fails++; $display("FAIL to_pulse got %0d want 1", n_to - t0); end
    tests++; if (n_rd - r0 !== 8) begin fails++; $display("FAIL to_reads got %0d want 8", n_rd - r0); end
    tests++; if (wr_data[w0] !== 64'h0002_0000_0000_0000) begin fails++; $display("FAIL to_csr0 got %h want 0002000000000000", wr_data[w0]); end
    tests++; if (done_cyc.size() - d0 !== 0) begin fails++; $display("FAIL to_nodone got %0d want 0", done_cyc.size() - d0); end
    tests++; if (err_cnt_o !== 8'd1) begin fails++; $display("FAIL to_err got %0d want 1", err_cnt_o); end
    tests++; if (last_status_o !== 64'h1) begin fails++; $display("FAIL to_status got %h want 1", last_status_o); end
  endtask

  task automatic test_op00;
    int w0, r0, wt;
    w0 = wr_addr.size(); r0 = n_rd;
    push_cmd(2'b00, 64'h1234, 64'h5678, wt);
    repeat (8) @(negedge clk_i);
    tests++; if (wr_addr.size() - w0 + n_rd - r0 !== 0) begin fails++; $display("FAIL op00_bus got %0d want 0", wr_addr.size() - w0 + n_rd - r0); end
    tests++; if (err_cnt_o !== 8'd2) begin fails++; $display("FAIL op00_err got %0d want 2", err_cnt_o); end
    tests++; if (cmd_ready_o !== 1'b1) begin fails++; $display("FAIL op00_ready got %b want 1", cmd_ready_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL op00_busy got %b want 0", busy_o); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  ops [6];
    logic [63:0] img [6];
    int w0, d0, t0, wt, wt5;
    bit ok;
    ops = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b10, 2'b11};
    img = '{64'hFFFD_FFFF_FFFC_FFFF, 64'hFFFF_FFFF_FFFC_FFFF, 64'hFFFE_FFFF_FFFC_FFFF,
            64'hFFFD_FFFF_FFFC_FFFF, 64'hFFFE_FFFF_FFFC_FFFF, 64'hFFFF_FFFF_FFFC_FFFF};
    w0 = wr_addr.size(); d0 = done_cyc.size(); t0 = n_to; wt5 = 0;
    for (int i = 0; i < 7; i++) st_tab[i] = IDLE_P;
    st_tab[7] = 64'h5;
    set_script(8, 64'h5);
    // First command is slow so the next four fill the FIFO and the fifth stalls.
    for (int i = 0; i < 6; i++) begin
      push_cmd(ops[i], 64'hFFFF_FFFF_FFFF_FFFF, 64'h100 + 64'(i), wt);
      if (i == 5) wt5 = wt;
    end
    wait_done(d0 + 6, 200, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_done got %b want 1", ok); end
    tests++; if ((wt5 > 0) !== 1'b1) begin fails++; $display("FAIL b2b_blocked got %0d want >0", wt5); end
    tests++; if (done_cyc.size() - d0 !== 6) begin fails++; $display("FAIL b2b_ndone got %0d want 6", done_cyc.size() - d0); end
    tests++; if (n_to - t0 !== 0) begin fails++; $display("FAIL b2b_timeout got %0d want 0", n_to - t0); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (wr_data[w0 + 2*i] !== img[i]) begin fails++; $display("FAIL b2b_csr0[%0d] got %h want %h", i, wr_data[w0 + 2*i], img[i]); end
      tests++; if (wr_data[w0 + 2*i + 1] !== 64'h100 + 64'(i)) begin fails++; $display("FAIL b2b_csr1[%0d] got %h want %h", i, wr_data[w0 + 2*i + 1], 64'h100 + 64'(i)); end
    end
    tests++; if (last_status_o !== 64'h5) begin fails++; $display("FAIL b2b_status got %h want 5", last_status_o); end
    tests++; if (err_cnt_o !== 8'd2) begin fails++; $display("FAIL b2b_err got %0d want 2", err_cnt_o); end
  endtask

  task automatic test_alternating;
    int d0, r0, wt;
    bit ok;
    d0 = done_cyc.size(); r0 = n_rd;
    st_tab[0] = 64'h0; st_tab[1] = IDLE_P; st_tab[2] = 64'h0; st_tab[3] = IDLE_P; st_tab[4] = 64'h2;
    set_script(5, IDLE_P);
    push_cmd(2'b01, 64'h0, 64'h0, wt);
    wait_done(d0 + 1, 60, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL alt_done got %b want 1", ok); end
    tests++; if (n_rd - r0 !== 5) begin fails++; $display("FAIL alt_reads got %0d want 5", n_rd - r0); end
    tests++; if (last_status_o !== 64'h2) begin fails++; $display("FAIL alt_status got %h want 2", last_status_o); end
  endtask

  task automatic test_reset_mid;
    int wt, t, w0, r0;
    set_script(0, IDLE_P);
    push_cmd(2'b10, 64'h0, 64'h0, wt);
    push_cmd(2'b01, 64'h0, 64'h0, wt);
    push_cmd(2'b11, 64'h0, 64'h0, wt);
    t = 0;
    while (!(mem_req_o && !mem_write_en_o) && t < 50) begin @(negedge clk_i); t++; end
    tests++; if (mem_req_o !== 1'b1) begin fails++; $display("FAIL rm_pollreq got %b want 1", mem_req_o); end
    rstn_i = 1'b0;
    @(negedge clk_i);
    tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL rm_req got %b want 0", mem_req_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rm_busy got %b want 0", busy_o); end
    tests++; if (err_cnt_o !== 8'd0) begin fails++; $display("FAIL rm_err got %0d want 0", err_cnt_o); end
    tests++; if (last_status_o !== 64'h0) begin fails++; $display("FAIL rm_status got %h want 0", last_status_o); end
    rstn_i = 1'b1;
    w0 = wr_addr.size(); r0 = n_rd;
    repeat (30) @(negedge clk_i);
    tests++; if (wr_addr.size() - w0 + n_rd - r0 !== 0) begin fails++; $display("FAIL rm_flushed got %0d want 0", wr_addr.size() - w0 + n_rd - r0); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rm_idle got %b want 0", busy_o); end
  endtask

  task automatic test_err_saturate;
    int w0;
    w0 = wr_addr.size();
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'b00;
    repeat (254) @(negedge clk_i);
    tests++; if (err_cnt_o !== 8'd254) begin fails++; $display("FAIL sat_254 got %0d want 254", err_cnt_o); end
    repeat (6) @(negedge clk_i);
    tests++; if (err_cnt_o !== 8'd255) begin fails++; $display("FAIL sat_255 got %0d want 255", err_cnt_o); end
    cmd_valid_i = 1'b0;
    tests++; if (wr_addr.size() - w0 !== 0) begin fails++; $display("FAIL sat_bus got %0d want 0", wr_addr.size() - w0); end
  endtask

  initial begin
    test_reset();
    test_delete();
    test_timeout();
    test_op00();
    test_back_to_back();
    test_alternating();
    test_reset_mid();
    test_err_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d cycles, limit 20000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
